// File: rtl/speech_sample_player_if.sv
// Flash word-read bus between the speech sample player (master) and the flash controller (slave).
// A read is accepted on a cycle with flash_read high and flash_waitrequest low.
interface speech_sample_player_if #(
  parameter int ADDR_W = 23
) ();
  logic [ADDR_W-1:0] flash_addr;
  logic              flash_read;
  logic              flash_waitrequest;
  logic [31:0]       flash_readdata;
  logic              flash_readdatavalid;

  modport master (
    output flash_addr,
    output flash_read,
    input  flash_waitrequest,
    input  flash_readdata,
    input  flash_readdatavalid
  );

  modport slave (
    input  flash_addr,
    input  flash_read,
    output flash_waitrequest,
    output flash_readdata,
    output flash_readdatavalid
  );
endinterface

// File: rtl/speech_sample_player.sv
// Plays one phrase of packed 8-bit samples from flash at a rate set by a clk-divide value.
// Each 32-bit word is fetched on demand and emitted LSB byte first, one byte per sample tick.
module speech_sample_player #(
  parameter int          ADDR_W  = 23,
  parameter int unsigned MAX_DIV = 65535,
  parameter int unsigned MIN_DIV = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           div_val,
  input  logic                  play,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  speech_sample_player_if.master flash,
  output logic [7:0]            sample_out,
  output logic                  sample_valid,
  output logic                  underrun,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    PLAY = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] end_reg, end_next;
  logic [15:0]       eff_reg, eff_next;
  logic [15:0]       cnt_reg, cnt_next;
  logic [31:0]       buf_reg, buf_next;
  logic [1:0]        idx_reg, idx_next;
  logic [7:0]        hold_reg, hold_next;
  logic              done_empty_reg, done_empty_next;
  logic              tick;
  logic [7:0]        word_bytes [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
      assign word_bytes[gi] = buf_reg[gi*8 +: 8];
    end
  endgenerate

  // Upstream arithmetic can underflow to huge values; those saturate at MAX_DIV.
  function automatic logic [15:0] clamp_div(input logic [31:0] d);
    if (d < 32'(MIN_DIV))
      return 16'(MIN_DIV);
    else if (d > 32'(MAX_DIV))
      return 16'(MAX_DIV);
    else
      return d[15:0];
  endfunction

  assign tick = (state_reg != IDLE) && (cnt_reg == eff_reg - 16'd1);

  assign busy            = (state_reg != IDLE);
  assign flash.flash_read = (state_reg == REQ);
  assign flash.flash_addr = (state_reg == REQ) ? addr_reg : '0;

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    end_next        = end_reg;
    eff_next        = eff_reg;
    cnt_next        = cnt_reg;
    buf_next        = buf_reg;
    idx_next        = idx_reg;
    hold_next       = hold_reg;
    done_empty_next = 1'b0;
    sample_valid    = 1'b0;
    underrun        = 1'b0;
    done            = done_empty_reg;
    sample_out      = hold_reg;

    // The divide is re-sampled only at period boundaries, so a speed change never truncates a period.
    if (state_reg != IDLE) begin
      if (tick) begin
        cnt_next = 16'd0;
        eff_next = clamp_div(div_val);
      end else begin
        cnt_next = cnt_reg + 16'd1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (play) begin
          if (end_addr < start_addr) begin
            done_empty_next = 1'b1;
          end else begin
            addr_next  = start_addr;
            end_next   = end_addr;
            eff_next   = clamp_div(div_val);
            cnt_next   = 16'd0;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        underrun = tick;
        if (!flash.flash_waitrequest)
          state_next = WAIT;
      end
      WAIT: begin
        underrun = tick;
        if (flash.flash_readdatavalid) begin
          buf_next   = flash.flash_readdata;
          idx_next   = 2'd0;
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          sample_valid = 1'b1;
          sample_out   = word_bytes[idx_reg];
          hold_next    = word_bytes[idx_reg];
          idx_next     = idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            if (addr_reg == end_reg) begin
              done       = 1'b1;
              state_next = IDLE;
            end else begin
              addr_next  = addr_reg + 1'b1;
              state_next = REQ;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      end_reg        <= '0;
      eff_reg        <= '0;
      cnt_reg        <= '0;
      buf_reg        <= '0;
      idx_reg        <= '0;
      hold_reg       <= '0;
      done_empty_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      end_reg        <= end_next;
      eff_reg        <= eff_next;
      cnt_reg        <= cnt_next;
      buf_reg        <= buf_next;
      idx_reg        <= idx_next;
      hold_reg       <= hold_next;
      done_empty_reg <= done_empty_next;
    end
  end

endmodule

// File: tb/tb_speech_sample_player.sv
// Directed bench for speech_sample_player: a flash responder, an output monitor with an
// expected-byte scoreboard, and one linear stimulus sequence.
module tb_speech_sample_player;
  localparam int ADDR_W = 23;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       div_val = '0;
  logic              play = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [7:0]        sample_out;
  logic              sample_valid;
  logic              underrun;
  logic              busy;
  logic              done;

  speech_sample_player_if #(.ADDR_W(ADDR_W)) fl ();

  speech_sample_player #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .div_val      (div_val),
    .play         (play),
    .start_addr   (start_addr),
    .end_addr     (end_addr),
    .flash        (fl),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .underrun     (underrun),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  int         sv_cyc[$];
  int         done_cyc[$];
  int         urun_cnt = 0;
  int         busy_fall = -1;
  logic       prev_busy = 1'b0;
  logic [7:0] last_sample = '0;

  int                rd_lat = 1;
  int                pend_cnt = 0;
  logic [ADDR_W-1:0] pend_addr = '0;
  logic [ADDR_W-1:0] stall_addr = '1;
  int                stall_left = 0;
  logic              stalling = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    logic [7:0] b;
    if (a == 23'h10) return 32'h44332211;
    b = 8'(a << 2);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic push_word(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = word_of(a);
    for (int k = 0; k < 4; k++) sb.push_back(w[8*k +: 8]);
  endtask

  function automatic int sc(input int i);
    if (i < sv_cyc.size()) return sv_cyc[i];
    return -1;
  endfunction

  function automatic int dc(input int i);
    if (i < done_cyc.size()) return done_cyc[i];
    return -1;
  endfunction

  task automatic wait1();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    sv_cyc.delete();
    done_cyc.delete();
    urun_cnt = 0;
    busy_fall = -1;
  endtask

  task automatic do_play(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                         input logic [31:0] d, output int c0);
    start_addr = s;
    end_addr   = e;
    div_val    = d;
    play       = 1'b1;
    c0         = cyc;
    wait1();
    play = 1'b0;
  endtask

  task automatic wait_samples(input int n, input int budget);
    int k;
    k = 0;
    while (sv_cyc.size() < n && k < budget) begin
      wait1();
      k++;
    end
    check("samples_seen", 32'(sv_cyc.size()), 32'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    last_sample = '0;
    wait1();
    reset = 1'b0;
  endtask

  // Output monitor: compares each sample against the scoreboard and logs event cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        if (sb.size() > 0) check("sample_value", 32'(sample_out), 32'(sb.pop_front()));
        check("no_underrun_with_sample", 32'(underrun), 32'd0);
        sv_cyc.push_back(cyc);
        last_sample = sample_out;
        $display("cycle %0d sample %02h", cyc, sample_out);
      end
      if (underrun) begin
        urun_cnt++;
        check("hold_on_underrun", 32'(sample_out), 32'(last_sample));
        $display("cycle %0d underrun", cyc);
      end
      if (done) begin
        done_cyc.push_back(cyc);
        $display("cycle %0d done", cyc);
      end
      if (prev_busy && !busy) busy_fall = cyc;
      prev_busy = busy;
    end
  end

  // Flash responder with configurable read latency and a one-shot stall at stall_addr.
  initial begin
    fl.flash_waitrequest   = 1'b0;
    fl.flash_readdata      = '0;
    fl.flash_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      if (stalling) begin
        check("stall_read_held", 32'(fl.flash_read), 32'd1);
        check("stall_addr_held", 32'(fl.flash_addr), 32'(stall_addr));
      end
      fl.flash_readdatavalid = 1'b0;
      fl.flash_waitrequest   = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          fl.flash_readdatavalid = 1'b1;
          fl.flash_readdata      = word_of(pend_addr);
        end
      end
      if (fl.flash_read && stall_left > 0 && fl.flash_addr == stall_addr) begin
        fl.flash_waitrequest = 1'b1;
        stall_left--;
        stalling = 1'b1;
      end else begin
        stalling = 1'b0;
        if (fl.flash_read) begin
          pend_cnt  = rd_lat;
          pend_addr = fl.flash_addr;
          $display("cycle %0d flash read accepted addr %0h", cyc, fl.flash_addr);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;

    // Reset state
    reset = 1'b1;
    repeat (3) wait1();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flash_read", 32'(fl.flash_read), 32'd0);
    check("rst_flash_addr", 32'(fl.flash_addr), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sample_out", 32'(sample_out), 32'd0);
    reset = 1'b0;
    wait1();

    // Normal rate, one word; a second play while busy must be ignored
    clear_obs();
    push_word(23'h10);
    do_play(23'h10, 23'h10, 32'd3472, c0);
    repeat (100) wait1();
    start_addr = 23'h50;
    end_addr   = 23'h50;
    play       = 1'b1;
    wait1();
    play = 1'b0;
    wait_samples(4, 20000);
    check("t1_first_latency", 32'(sc(0) - c0), 32'd3472);
    for (int i = 1; i < 4; i++) check("t1_spacing", 32'(sc(i) - sc(i-1)), 32'd3472);
    repeat (20) wait1();
    check("t1_sample_count", 32'(sv_cyc.size()), 32'd4);
    check("t1_done_count", 32'(done_cyc.size()), 32'd1);
    check("t1_done_with_last", 32'(dc(0)), 32'(sc(3)));
    check("t1_busy_fall", 32'(busy_fall), 32'(sc(3) + 1));
    check("t1_sb_drained", 32'(sb.size()), 32'd0);

    // Underflowed divide clamps to MAX_DIV; a mid-period change applies from the next period
    clear_obs();
    push_word(23'h20);
    do_play(23'h20, 23'h20, 32'hFFFFEE48, c0);
    repeat (30000) wait1();
    div_val = 32'd8472;
    wait_samples(2, 80000);
    check("t2_clamp_max", 32'(sc(0) - c0), 32'd65535);
    check("t2_midchange_8472", 32'(sc(1) - sc(0)), 32'd8472);
    do_reset();

    // div_val=0 clamps to 2; 10-cycle stall on the second word
    clear_obs();
    push_word(23'h30);
    push_word(23'h31);
    stall_addr = 23'h31;
    stall_left = 10;
    do_play(23'h30, 23'h31, 32'd0, c0);
    wait_samples(8, 300);
    check("t3_first_latency", 32'(sc(0) - c0), 32'd4);
    check("t3_min_spacing", 32'(sc(1) - sc(0)), 32'd2);
    check("t3_second_word_start", 32'(sc(4) - c0), 32'd24);
    repeat (5) wait1();
    check("t3_underruns", 32'(urun_cnt), 32'd7);
    check("t3_done_with_last", 32'(dc(0)), 32'(sc(7)));
    check("t3_sb_drained", 32'(sb.size()), 32'd0);

    // Reset while waiting for data; the late data word must be ignored
    clear_obs();
    push_word(23'h40);
    rd_lat = 20;
    do_play(23'h40, 23'h40, 32'd100, c0);
    repeat (3) wait1();
    check("t4_busy_in_wait", 32'(busy), 32'd1);
    check("t4_read_low_in_wait", 32'(fl.flash_read), 32'd0);
    do_reset();
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_flash_read", 32'(fl.flash_read), 32'd0);
    check("t4_flash_addr", 32'(fl.flash_addr), 32'd0);
    check("t4_sample_valid", 32'(sample_valid), 32'd0);
    check("t4_underrun", 32'(underrun), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_sample_out", 32'(sample_out), 32'd0);
    repeat (40) wait1();
    check("t4_no_stale_samples", 32'(sv_cyc.size()), 32'd0);
    check("t4_idle_after_stale", 32'(busy), 32'd0);
    rd_lat = 1;
    clear_obs();
    push_word(23'h40);
    do_play(23'h40, 23'h40, 32'd5, c0);
    wait_samples(4, 200);
    check("t4_replay_latency", 32'(sc(0) - c0), 32'd5);
    check("t4_replay_spacing", 32'(sc(3) - sc(2)), 32'd5);
    check("t4_replay_done", 32'(dc(0)), 32'(sc(3)));

    // end_addr < start_addr: done next cycle, no read, never busy
    repeat (5) wait1();
    clear_obs();
    do_play(23'h60, 23'h5F, 32'd10, c0);
    check("t5_done_next", 32'(done), 32'd1);
    check("t5_not_busy", 32'(busy), 32'd0);
    check("t5_no_read", 32'(fl.flash_read), 32'd0);
    wait1();
    check("t5_done_one_cycle", 32'(done), 32'd0);
    check("t5_no_read_after", 32'(fl.flash_read), 32'd0);
    repeat (20) wait1();
    check("t5_done_count", 32'(done_cyc.size()), 32'd1);
    check("t5_no_samples", 32'(sv_cyc.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/speech_sample_player.md
Name: speech_sample_player

Overview:
- Sits directly downstream of the speed selector.
- Consumes its 32-bit clock-divide value (clk cycles per audio sample), generates the sample-rate tick, fetches 32-bit words from flash over a read handshake, and unpacks each word into four 8-bit audio samples for the audio DAC interface.
- Plays one phrase, start_addr..end_addr inclusive, per play request.

Parameters:
- ADDR_W, 23, flash word-address width.
- MAX_DIV, 65535, upper clamp for effective divide value.
- MIN_DIV, 2, lower clamp for effective divide value.

Ports:
- clk  in  1  system clock (25 MHz).
- reset  in  1  synchronous, active-high; returns block to IDLE.
- div_val  in  32  clk cycles per sample, from speed selector.
- play  in  1  one-cycle start pulse; ignored unless IDLE.
- start_addr  in  ADDR_W  first flash word address of phrase.
- end_addr  in  ADDR_W  last flash word address of phrase (inclusive).
- flash_addr  out  ADDR_W  flash word address.
- flash_read  out  1  read request, held until accepted.
- flash_waitrequest  in  1  flash stall; request accepted on cycle with flash_read=1, flash_waitrequest=0.
- flash_readdata  in  32  returned word.
- flash_readdatavalid  in  1  flash_readdata valid this cycle.
- sample_out  out  8  current audio sample (two's complement).
- sample_valid  out  1  one-cycle pulse, new sample_out this cycle.
- underrun  out  1  one-cycle pulse, tick arrived with no data buffered.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when last byte of end_addr word is output.

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0.
  - tick counter=0; byte index=0; word buffer empty.
- Effective divide:
  - eff = MIN_DIV if div_val<MIN_DIV; MAX_DIV if div_val>MAX_DIV; else div_val[15:0].
  - Upstream underflow (e.g. 0xFFFFEE48) clamps to MAX_DIV.
- Tick generator:
  - Runs only when state!=IDLE; counter cleared on entry from IDLE.
  - Counts 0..eff-1; tick asserted in the cycle the counter equals eff-1, then counter wraps to 0.
  - eff re-sampled from div_val only at play acceptance and on each tick. A mid-period speed change takes effect on the next period, never truncating the current one.
- States:
  - IDLE:
    - On play: latch addr=start_addr and end_addr, load eff, go REQ.
    - If end_addr<start_addr: done pulse next cycle, stay IDLE.
  - REQ:
    - flash_read=1, flash_addr=addr.
    - When accepted: deassert flash_read next cycle, go WAIT.
  - WAIT:
    - On flash_readdatavalid: load buffer, byte index=0, go PLAY.
  - PLAY:
    - On tick: sample_out=buffer byte[idx], LSB byte first (bits 7:0, then 15:8, 23:16, 31:24); sample_valid=1; idx++.
    - After byte 3:
      - If addr==end_addr: done=1 in the same cycle as that sample_valid, go IDLE.
      - Else: addr++, go REQ.
- Underrun:
  - A tick while in REQ/WAIT pulses underrun; sample_out holds its last value; no sample_valid.
  - The tick period is not stretched.
- Latency: first sample_valid is on the first tick after the first word arrives. No prefetch; single-word buffer.
- play while busy: ignored.
- Reset mid-operation:
  - Abandons any outstanding read; flash_read drops the next cycle.
  - A flash_readdatavalid arriving after reset is ignored because the block is in IDLE.
- Simultaneous:
  - tick and flash_readdatavalid in the same cycle in WAIT: underrun pulses, the word is loaded, and the first byte goes out on the next tick.
  - reset has priority over everything.
- Address increment wraps modulo 2^ADDR_W.

Test Plan:
- Normal rate: div_val=3472, start=0x10, end=0x10, word 0x44332211, zero-wait flash.
  - sample_valid pulses exactly 3472 cycles apart with samples 0x11, 0x22, 0x33, 0x44.
  - done coincides with the 0x44 pulse; busy drops the next cycle.
- Clamping:
  - div_val=0xFFFFEE48 gives a tick spacing of 65535 cycles.
  - div_val=0 gives a spacing of 2 cycles.
  - div_val=8472 gives a spacing of 8472 cycles.
- Mid-play speed change: div_val switched 3472→8472 partway through a period.
  - The current interval stays 3472 cycles; the following interval is 8472 cycles.
- Flash stall: waitrequest high for 10 cycles at the second word, div_val=2.
  - flash_read and flash_addr stay stable throughout the stall.
  - underrun pulses on each tick that lands during REQ/WAIT; sample order stays intact (8 bytes, 2 words).
- Reset mid-phrase: assert reset during WAIT, then deliver a stale readdatavalid.
  - All outputs are 0 one cycle after reset; no sample_valid follows.
  - A subsequent play runs normally.
- Edge cases:
  - end_addr<start_addr gives done the next cycle with no flash_read.
  - play while busy is ignored: done pulses once only.
